// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encodings and widths for the pipeline hazard sequencer
package hazard_pkg;

    localparam int REG_W_DEF = 5;
    localparam int STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between ID sources and the EX load destination
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             rs1Used,
    input  logic             rs2Used,
    input  logic [REG_W-1:0] rw,
    input  logic             loadEn,
    output logic             hz
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hz = loadEn && (rw != '0) &&
                ((rs1Used && (rs1 == rw)) || (rs2Used && (rs2 == rw)));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencer for the 5-stage core; HAZARD_PERF_CNT_EN adds stallCnt
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   rs1,
    input  logic [REG_W-1:0]   rs2,
    input  logic               rs1Used,
    input  logic               rs2Used,
    input  logic [REG_W-1:0]   rw,
    input  logic               loadEn,
    input  logic               brTaken,
    input  logic               memReq,
    input  logic               memReady,
    output logic               pcEn,
    output logic               ifidEn,
    output logic               idexEn,
    output logic               exmemEn,
    output logic               ifidFlush,
    output logic               idexFlush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0]   stallCnt,
`endif
    output logic [STATE_W-1:0] state
);

    localparam logic [2:0] LCNT_INIT = 3'(LOAD_LAT - 1);

    hz_state_t  cur;
    hz_state_t  nxt;
    logic [2:0] lcnt;
    logic [2:0] lcnt_nxt;
    logic       hz;
    logic       mem_wait;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .rs1     (rs1),
        .rs2     (rs2),
        .rs1Used (rs1Used),
        .rs2Used (rs2Used),
        .rw      (rw),
        .loadEn  (loadEn),
        .hz      (hz)
    );

    assign mem_wait = memReq && !memReady;
    assign state    = cur;

    always_comb begin
        pcEn      = 1'b1;
        ifidEn    = 1'b1;
        idexEn    = 1'b1;
        exmemEn   = 1'b1;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        nxt       = cur;
        lcnt_nxt  = lcnt;
        if (rst) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexEn    = 1'b0;
            exmemEn   = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            nxt       = RUN;
            lcnt_nxt  = 3'd0;
        end else begin
            case (cur)
                RUN: begin
                    if (mem_wait) begin
                        pcEn    = 1'b0;
                        ifidEn  = 1'b0;
                        idexEn  = 1'b0;
                        exmemEn = 1'b0;
                        nxt     = MWAIT;
                    end else if (brTaken) begin
                        // the ID instruction is wrong-path, so its hazard is irrelevant
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                    end else if (hz) begin
                        pcEn      = 1'b0;
                        ifidEn    = 1'b0;
                        idexFlush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            nxt      = LSTALL;
                            lcnt_nxt = LCNT_INIT;
                        end
                    end
                end
                LSTALL: begin
                    pcEn      = 1'b0;
                    ifidEn    = 1'b0;
                    idexFlush = 1'b1;
                    // the older load still in MEM may be waiting; freeze the countdown with it
                    if (mem_wait) begin
                        exmemEn = 1'b0;
                    end else if (lcnt == 3'd1) begin
                        nxt      = RUN;
                        lcnt_nxt = 3'd0;
                    end else begin
                        lcnt_nxt = lcnt - 3'd1;
                    end
                end
                MWAIT: begin
                    if (!memReady) begin
                        pcEn    = 1'b0;
                        ifidEn  = 1'b0;
                        idexEn  = 1'b0;
                        exmemEn = 1'b0;
                    end else begin
                        nxt = RUN;
                    end
                end
                default: begin
                    nxt      = RUN;
                    lcnt_nxt = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= RUN;
            lcnt <= 3'd0;
        end else begin
            cur  <= nxt;
            lcnt <= lcnt_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if ((!pcEn || ifidFlush || idexFlush) && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench driving LOAD_LAT=1 and LOAD_LAT=3 instances in lockstep
module tb_hazard_ctrl;

    localparam logic [5:0] O_DEF = 6'b111100;
    localparam logic [5:0] O_RST = 6'b000011;
    localparam logic [5:0] O_LST = 6'b001101;
    localparam logic [5:0] O_BR  = 6'b111111;
    localparam logic [5:0] O_MW  = 6'b000000;
    localparam logic [5:0] O_LMW = 6'b001001;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rw;
    logic       rs1Used, rs2Used, loadEn, brTaken, memReq, memReady;

    logic       pcEn1, ifidEn1, idexEn1, exmemEn1, ifidFlush1, idexFlush1;
    logic       pcEn3, ifidEn3, idexEn3, exmemEn3, ifidFlush3, idexFlush3;
    logic [1:0] state1, state3;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stallCnt1, stallCnt3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1Used(rs1Used), .rs2Used(rs2Used),
        .rw(rw), .loadEn(loadEn), .brTaken(brTaken), .memReq(memReq), .memReady(memReady),
        .pcEn(pcEn1), .ifidEn(ifidEn1), .idexEn(idexEn1), .exmemEn(exmemEn1),
        .ifidFlush(ifidFlush1), .idexFlush(idexFlush1),
`ifdef HAZARD_PERF_CNT_EN
        .stallCnt(stallCnt1),
`endif
        .state(state1)
    );

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1Used(rs1Used), .rs2Used(rs2Used),
        .rw(rw), .loadEn(loadEn), .brTaken(brTaken), .memReq(memReq), .memReady(memReady),
        .pcEn(pcEn3), .ifidEn(ifidEn3), .idexEn(idexEn3), .exmemEn(exmemEn3),
        .ifidFlush(ifidFlush3), .idexFlush(idexFlush3),
`ifdef HAZARD_PERF_CNT_EN
        .stallCnt(stallCnt3),
`endif
        .state(state3)
    );

    wire [7:0] obs1 = {pcEn1, ifidEn1, idexEn1, exmemEn1, ifidFlush1, idexFlush1, state1};
    wire [7:0] obs3 = {pcEn3, ifidEn3, idexEn3, exmemEn3, ifidFlush3, idexFlush3, state3};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ld, input logic [4:0] d, input logic [4:0] s1, input logic u1,
                         input logic [4:0] s2, input logic u2, input logic br,
                         input logic mq, input logic mr);
        loadEn = ld; rw = d; rs1 = s1; rs1Used = u1; rs2 = s2; rs2Used = u2;
        brTaken = br; memReq = mq; memReady = mr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // both instances see the same inputs; expectations differ only through LOAD_LAT
    task automatic both(input string tag, input logic [5:0] o1, input logic [1:0] s1,
                        input logic [5:0] o3, input logic [1:0] s3);
        check({tag, "/lat1"}, obs1, {o1, s1});
        check({tag, "/lat3"}, obs3, {o3, s3});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        both("reset", O_RST, 2'd0, O_RST, 2'd0);
        tick();
        rst = 1'b0;
        idle();
        both("idle_after_reset", O_DEF, 2'd0, O_DEF, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_after_reset", stallCnt1[7:0], 8'd0);
`endif
        tick();

        // load-use on rs1: one bubble at LOAD_LAT=1, three at LOAD_LAT=3
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        both("lu_c1", O_LST, 2'd0, O_LST, 2'd0);
        tick();
        idle();
        both("lu_c2", O_DEF, 2'd0, O_LST, 2'd1);
        tick();
        both("lu_c3", O_DEF, 2'd0, O_LST, 2'd1);
        tick();
        both("lu_c4", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // loads to x0 and unused operands never stall
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        both("x0_dest", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        both("rs2_unused", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();
        drive(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        both("not_load", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // rs2 dependency
        drive(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        both("rs2_c1", O_LST, 2'd0, O_LST, 2'd0);
        tick();
        idle();
        both("rs2_c2", O_DEF, 2'd0, O_LST, 2'd1);
        tick();
        both("rs2_c3", O_DEF, 2'd0, O_LST, 2'd1);
        tick();
        both("rs2_c4", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // taken branch overrides a simultaneous hazard
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        both("br_hz", O_BR, 2'd0, O_BR, 2'd0);
        tick();
        idle();
        both("br_after", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // request completing in the same cycle is not a wait
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        both("mem_same_cycle", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // four cycles of memReady=0 then ready
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        both("mw_c1", O_MW, 2'd0, O_MW, 2'd0);
        tick();
        both("mw_c2", O_MW, 2'd2, O_MW, 2'd2);
        tick();
        both("mw_c3", O_MW, 2'd2, O_MW, 2'd2);
        tick();
        both("mw_c4", O_MW, 2'd2, O_MW, 2'd2);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        both("mw_ready", O_DEF, 2'd2, O_DEF, 2'd2);
        tick();
        idle();
        both("mw_after", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // memory wait during LSTALL freezes EX/MEM and holds the countdown
        drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        both("lmw_a", O_LST, 2'd0, O_LST, 2'd0);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        both("lmw_b", O_MW, 2'd0, O_LMW, 2'd1);
        tick();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        both("lmw_c", O_DEF, 2'd2, O_LST, 2'd1);
        tick();
        idle();
        both("lmw_d", O_DEF, 2'd0, O_LST, 2'd1);
        tick();
        both("lmw_e", O_DEF, 2'd0, O_DEF, 2'd0);
        tick();

        // reset on the second stall cycle of a LOAD_LAT=3 hazard
        drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        both("rst_mid_a", O_LST, 2'd0, O_LST, 2'd0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        both("rst_mid_b", O_RST, 2'd0, O_RST, 2'd1);
        tick();
        rst = 1'b0;
        #1;
        both("rst_mid_c", O_DEF, 2'd0, O_DEF, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_rst_mid", stallCnt3[7:0], 8'd0);
`endif
        tick();
        both("rst_mid_d", O_DEF, 2'd0, O_DEF, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("cnt_no_residual", stallCnt3[7:0], 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline stall/flush sequencer for the 5-stage RISC-V core.
- Replaces clock gating with synchronous enable/flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Arbitrates three stall sources with fixed priority: data-memory wait, then taken-branch redirect, then load-use hazard.
- Sits between decode/EX/MEM stage signals and the pipeline register enables.

Parameters:
REG_W, 5, register-index width
LOAD_LAT, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of stall performance counter

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rs1  input  REG_W  ID-stage source register 1
rs2  input  REG_W  ID-stage source register 2
rs1Used  input  1  ID instruction reads rs1
rs2Used  input  1  ID instruction reads rs2
rw  input  REG_W  EX-stage destination register
loadEn  input  1  EX-stage instruction is a load
brTaken  input  1  EX-stage branch/jump resolved taken
memReq  input  1  MEM-stage access in progress
memReady  input  1  data memory completes access this cycle
pcEn  output  1  PC register enable
ifidEn  output  1  IF/ID register enable
idexEn  output  1  ID/EX register enable
exmemEn  output  1  EX/MEM register enable
ifidFlush  output  1  IF/ID load NOP
idexFlush  output  1  ID/EX load NOP (bubble)
state  output  2  current FSM state (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State register: FSM state, load-stall counter lcnt (3 bits).
- Outputs: combinational from the current state and inputs, so a stall takes effect in the same cycle it is detected.
- While rst=1:
  - all enables are 0; ifidFlush=1, idexFlush=1.
  - Next state is RUN, lcnt=0.
  - Applies mid-stall too; no stall state survives reset.
- Hazard condition: hz = loadEn & (rw!=0) & ((rs1Used & rs1==rw) | (rs2Used & rs2==rw)).
  - Writes to x0 never stall.
- States: RUN=0, LSTALL=1, MWAIT=2.
- Default outputs: all enables 1, both flushes 0.
- RUN, priority order:
  1. memReq & !memReady: all enables 0, no flush. Next state MWAIT.
  2. brTaken: ifidFlush=1, idexFlush=1, pcEn=1. Any hz is ignored (wrong-path instruction). Stay in RUN.
  3. hz: pcEn=0, ifidEn=0, idexFlush=1.
     - If LOAD_LAT=1, stay in RUN.
     - Otherwise go to LSTALL with lcnt=LOAD_LAT-1.
  4. else: defaults.
- LSTALL:
  - pcEn=0, ifidEn=0, idexFlush=1; lcnt decrements each cycle.
  - When lcnt==1, next state is RUN.
  - memReq & !memReady during LSTALL also drives exmemEn=0 and holds lcnt. memReq here belongs to the older load in MEM.
  - brTaken cannot occur here (EX holds a bubble); it is ignored.
- MWAIT:
  - All enables 0, no flush, until memReady=1.
  - On the memReady cycle: all enables 1, next state RUN.
  - brTaken/hz are held in their frozen stages and are re-evaluated in the following RUN cycle.
- Simultaneous memReq&memReady in RUN is not a wait; normal RUN priority applies.
- Latency: a load-use hazard costs exactly LOAD_LAT cycles; a taken branch costs 2 flushed slots; a memory wait costs N cycles of memReady=0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output stallCnt (CNT_W).
  - Increments on every cycle with pcEn=0 or a flush, excluding reset.
  - Saturates at all-ones; clears on rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg: state encodings RUN/LSTALL/MWAIT, REG_W default, state width constant.
- One sub-module, hazard_detect: combinational hz comparator (rs1/rs2/rw/used/loadEn), reusable for rs2-only forwarding checks.

Test Plan:
- Load-use, LOAD_LAT=1: loadEn=1, rw=5, rs1=5, rs1Used=1 in RUN -> one cycle pcEn=0, ifidEn=0, idexFlush=1; next cycle (loadEn=0) all defaults.
- x0 / unused operand: rw=0 with rs1=0, or rs2==rw with rs2Used=0 -> no stall; outputs at defaults.
- LOAD_LAT=3 hazard -> exactly 3 consecutive stall cycles with state 0→1→1→0.
- Branch+hazard: brTaken=1 and hz=1 same cycle -> ifidFlush=idexFlush=1, pcEn=1, state stays RUN.
- Memory wait: memReq=1, memReady=0 for 4 cycles then 1 -> 4 cycles all enables 0 in MWAIT, enables 1 on the ready cycle, RUN next.
- Reset mid-LSTALL: rst=1 at LOAD_LAT=3 second stall cycle -> state RUN, lcnt=0, no residual stall after release (stallCnt=0 if HAZARD_PERF_CNT_EN).
